// File: rtl/dense_layer_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_engine_pkg
// Purpose  : Shared defaults, width helper and FSM encoding for the dense layer.
// Revision : 1.0 - initial release
// ============================================================================
package dense_layer_engine_pkg;

    // Defaults shared with the ROM generators
    localparam int c_def_n_in  = 784;
    localparam int c_def_n_out = 10;
    localparam int c_def_dw    = 32;
    localparam int c_def_ww    = 32;
    localparam int c_def_ow    = 32;
    localparam int c_def_accw  = 64;
    localparam int c_def_shift = 16;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_POST   = 3'd3,
        ST_ARGMAX = 3'd4,
        ST_OUT    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dense_layer_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_engine_if
// Purpose  : Start/ROM/result signal bundle of the dense layer engine.
// Revision : 1.0 - initial release
// ============================================================================
interface dense_layer_engine_if
    import dense_layer_engine_pkg::*;
#(
    parameter int N_IN  = c_def_n_in,
    parameter int N_OUT = c_def_n_out,
    parameter int DW    = c_def_dw,
    parameter int WW    = c_def_ww,
    parameter int OW    = c_def_ow
) ();
    localparam int AW = addr_width(N_IN);
    localparam int IW = $clog2(N_OUT);

    logic                  start;
    logic                  busy;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [DW-1:0]         x_data;
    logic [N_OUT*WW-1:0]   w_data;
    logic [N_OUT*OW-1:0]   bias_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_OUT*OW-1:0]   out_data;
    logic [IW-1:0]         out_argmax;

    modport master (
        input  start, x_data, w_data, bias_data, out_ready,
        output busy, rd_en, rd_addr, out_valid, out_data, out_argmax
    );

    modport slave (
        output start, x_data, w_data, bias_data, out_ready,
        input  busy, rd_en, rd_addr, out_valid, out_data, out_argmax
    );

endinterface
`default_nettype wire

// File: rtl/dense_layer_engine_mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_engine_mac_lane
// Purpose  : One neuron: bias preload, MAC, rescale, optional ReLU, saturation.
// Revision : 1.0 - initial release
// ============================================================================
module dense_layer_engine_mac_lane #(
    parameter int DW      = 32,
    parameter int WW      = 32,
    parameter int OW      = 32,
    parameter int ACCW    = 64,
    parameter int SHIFT   = 16,
    parameter int RELU_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 mac_en,
    input  logic                 post_en,
    input  logic signed [DW-1:0] x,
    input  logic signed [WW-1:0] w,
    input  logic signed [OW-1:0] bias,
    output logic signed [OW-1:0] result
);
    localparam logic signed [ACCW-1:0] c_sat_max = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] c_sat_min = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [ACCW-1:0]  r_acc;
    logic signed [OW-1:0]    r_result;
    logic signed [DW+WW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_shr;
    logic signed [OW-1:0]    w_res;

    assign w_prod = x * w;
    assign w_shr  = r_acc >>> SHIFT;
    assign result = r_result;

    always_comb begin
        w_res = w_shr[OW-1:0];
        if (RELU_EN != 0 && w_shr[ACCW-1]) begin
            w_res = '0;
        end else if (w_shr > c_sat_max) begin
            w_res = {1'b0, {(OW-1){1'b1}}};
        end else if (w_shr < c_sat_min) begin
            w_res = {1'b1, {(OW-1){1'b0}}};
        end
    end

    // Bias is pre-scaled so the same shift removes the fraction from both terms
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (load) begin
                r_acc <= ACCW'(bias) <<< SHIFT;
            end else if (mac_en) begin
                r_acc <= r_acc + ACCW'(w_prod);
            end
            if (post_en) begin
                r_result <= w_res;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dense_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_engine
// Purpose  : Fully-connected layer with N_OUT MAC lanes, ROM sequencing, argmax.
// Revision : 1.0 - initial release
// ============================================================================
module dense_layer_engine
    import dense_layer_engine_pkg::*;
#(
    parameter int N_IN    = c_def_n_in,
    parameter int N_OUT   = c_def_n_out,
    parameter int DW      = c_def_dw,
    parameter int WW      = c_def_ww,
    parameter int OW      = c_def_ow,
    parameter int ACCW    = c_def_accw,
    parameter int SHIFT   = c_def_shift,
    parameter int RELU_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dense_layer_engine_if.master bus
);
    localparam int AW = addr_width(N_IN);
    localparam int IW = $clog2(N_OUT);
    localparam logic [AW-1:0] c_last_addr = AW'(N_IN - 1);
    localparam logic [IW-1:0] c_last_lane = IW'(N_OUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_addr;
    logic                  r_vld;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_argmax;
    logic signed [OW-1:0]  r_max;
    logic signed [OW-1:0]  w_lane_res [N_OUT];
    logic [N_OUT*OW-1:0]   w_out_data;
    logic                  w_load;
    logic                  w_post;
    logic                  w_busy;
    logic                  w_rd_en;
    logic                  w_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_vld    <= 1'b0;
            r_idx    <= '0;
            r_argmax <= '0;
            r_max    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= w_rd_en;
            if (w_rd_en && r_addr != c_last_addr) begin
                r_addr <= r_addr + AW'(1);
            end else begin
                r_addr <= '0;
            end
            // Lane 0 seeds the scan, so a stale maximum never leaks across runs
            if (r_state == ST_ARGMAX) begin
                if (r_idx == '0 || w_lane_res[r_idx] > r_max) begin
                    r_max    <= w_lane_res[r_idx];
                    r_argmax <= r_idx;
                end
                r_idx <= (r_idx == c_last_lane) ? '0 : r_idx + IW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_rd_en     = 1'b0;
        w_out_valid = 1'b0;
        w_load      = 1'b0;
        w_post      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_rd_en = 1'b1;
                if (r_addr == c_last_addr) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN:  w_state_nxt = ST_POST;
            ST_POST: begin
                w_post      = 1'b1;
                w_state_nxt = ST_ARGMAX;
            end
            ST_ARGMAX: begin
                if (r_idx == c_last_lane) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
        dense_layer_engine_mac_lane #(
            .DW      (DW),
            .WW      (WW),
            .OW      (OW),
            .ACCW    (ACCW),
            .SHIFT   (SHIFT),
            .RELU_EN (RELU_EN)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (w_load),
            .mac_en  (r_vld),
            .post_en (w_post),
            .x       (bus.x_data),
            .w       (bus.w_data[gi*WW +: WW]),
            .bias    (bus.bias_data[gi*OW +: OW]),
            .result  (w_lane_res[gi])
        );
    end

    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_out_data[i*OW +: OW] = w_lane_res[i];
        end
    end

    assign bus.busy       = w_busy;
    assign bus.rd_en      = w_rd_en;
    assign bus.rd_addr    = r_addr;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_data;
    assign bus.out_argmax = r_argmax;

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_layer_engine
// Purpose  : Directed vector bench for four small dense_layer_engine configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_layer_engine;

    // sel 0: RELU, SHIFT 0 | sel 1: no RELU | sel 2: SHIFT 8, OW 16, no RELU | sel 3: N_IN 1
    typedef struct packed {
        logic [1:0]             sel;
        logic [0:3][31:0]       x;
        logic [0:2][0:3][31:0]  w;
        logic [0:2][31:0]       b;
        logic [0:2][31:0]       e;
        logic [1:0]             arg;
    } vec_t;

    localparam logic [31:0] c_junk = 32'h5A5A_A5A5;
    localparam int c_lat [4] = '{10, 10, 10, 7};
    localparam int c_nin [4] = '{4, 4, 4, 1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t cur;
    vec_t vecs [9];
    logic [0:2][31:0] bias_drv;

    logic        t_start [4];
    logic        t_ready [4];
    logic        t_busy  [4];
    logic        t_rden  [4];
    logic [1:0]  t_addr  [4];
    logic        t_valid [4];
    logic [31:0] t_data  [4][3];
    logic [1:0]  t_arg   [4];

    dense_layer_engine_if #(.N_IN(4), .N_OUT(3), .DW(32), .WW(32), .OW(32)) if_a ();
    dense_layer_engine_if #(.N_IN(4), .N_OUT(3), .DW(32), .WW(32), .OW(32)) if_b ();
    dense_layer_engine_if #(.N_IN(4), .N_OUT(3), .DW(32), .WW(32), .OW(16)) if_c ();
    dense_layer_engine_if #(.N_IN(1), .N_OUT(3), .DW(32), .WW(32), .OW(32)) if_d ();

    dense_layer_engine #(.N_IN(4), .N_OUT(3), .DW(32), .WW(32), .OW(32), .ACCW(64), .SHIFT(0), .RELU_EN(1))
        u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    dense_layer_engine #(.N_IN(4), .N_OUT(3), .DW(32), .WW(32), .OW(32), .ACCW(64), .SHIFT(0), .RELU_EN(0))
        u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    dense_layer_engine #(.N_IN(4), .N_OUT(3), .DW(32), .WW(32), .OW(16), .ACCW(64), .SHIFT(8), .RELU_EN(0))
        u_dut_c (.clk(clk), .rst(rst), .bus(if_c));
    dense_layer_engine #(.N_IN(1), .N_OUT(3), .DW(32), .WW(32), .OW(32), .ACCW(64), .SHIFT(0), .RELU_EN(1))
        u_dut_d (.clk(clk), .rst(rst), .bus(if_d));

    assign if_a.start = t_start[0];  assign if_a.out_ready = t_ready[0];
    assign if_b.start = t_start[1];  assign if_b.out_ready = t_ready[1];
    assign if_c.start = t_start[2];  assign if_c.out_ready = t_ready[2];
    assign if_d.start = t_start[3];  assign if_d.out_ready = t_ready[3];

    assign if_a.bias_data = {bias_drv[2], bias_drv[1], bias_drv[0]};
    assign if_b.bias_data = {bias_drv[2], bias_drv[1], bias_drv[0]};
    assign if_c.bias_data = {bias_drv[2][15:0], bias_drv[1][15:0], bias_drv[0][15:0]};
    assign if_d.bias_data = {bias_drv[2], bias_drv[1], bias_drv[0]};

    // Synchronous ROMs: data follows rd_en by one cycle, junk otherwise
    always @(posedge clk) begin
        if_a.x_data <= if_a.rd_en ? cur.x[if_a.rd_addr] : c_junk;
        if_b.x_data <= if_b.rd_en ? cur.x[if_b.rd_addr] : c_junk;
        if_c.x_data <= if_c.rd_en ? cur.x[if_c.rd_addr] : c_junk;
        if_d.x_data <= if_d.rd_en ? cur.x[if_d.rd_addr] : c_junk;
        for (int i = 0; i < 3; i++) begin
            if_a.w_data[i*32 +: 32] <= if_a.rd_en ? cur.w[i][if_a.rd_addr] : c_junk;
            if_b.w_data[i*32 +: 32] <= if_b.rd_en ? cur.w[i][if_b.rd_addr] : c_junk;
            if_c.w_data[i*32 +: 32] <= if_c.rd_en ? cur.w[i][if_c.rd_addr] : c_junk;
            if_d.w_data[i*32 +: 32] <= if_d.rd_en ? cur.w[i][if_d.rd_addr] : c_junk;
        end
    end

    always_comb begin
        t_busy[0]  = if_a.busy;       t_busy[1]  = if_b.busy;
        t_busy[2]  = if_c.busy;       t_busy[3]  = if_d.busy;
        t_rden[0]  = if_a.rd_en;      t_rden[1]  = if_b.rd_en;
        t_rden[2]  = if_c.rd_en;      t_rden[3]  = if_d.rd_en;
        t_addr[0]  = if_a.rd_addr;    t_addr[1]  = if_b.rd_addr;
        t_addr[2]  = if_c.rd_addr;    t_addr[3]  = {1'b0, if_d.rd_addr};
        t_valid[0] = if_a.out_valid;  t_valid[1] = if_b.out_valid;
        t_valid[2] = if_c.out_valid;  t_valid[3] = if_d.out_valid;
        t_arg[0]   = if_a.out_argmax; t_arg[1]   = if_b.out_argmax;
        t_arg[2]   = if_c.out_argmax; t_arg[3]   = if_d.out_argmax;
        for (int i = 0; i < 3; i++) begin
            t_data[0][i] = if_a.out_data[i*32 +: 32];
            t_data[1][i] = if_b.out_data[i*32 +: 32];
            t_data[2][i] = {{16{if_c.out_data[i*16+15]}}, if_c.out_data[i*16 +: 16]};
            t_data[3][i] = if_d.out_data[i*32 +: 32];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] sel, input logic [0:3][31:0] x,
                                 input logic [0:3][31:0] w0, input logic [0:3][31:0] w1,
                                 input logic [0:3][31:0] w2, input logic [0:2][31:0] b,
                                 input logic [0:2][31:0] e, input logic [1:0] arg);
        vec_t v;
        v.sel = sel; v.x = x; v.w = {w0, w1, w2}; v.b = b; v.e = e; v.arg = arg;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input bit stall);
        int s;
        int k;
        int n_rd;
        bit addr_bad;
        s = int'(v.sel);
        cur = v;
        bias_drv = v.b;
        t_ready[s] = !stall;
        t_start[s] = 1'b1;
        @(posedge clk); #1;
        t_start[s] = 1'b0;
        bias_drv = {3{c_junk}};
        k = 0; n_rd = 0; addr_bad = 1'b0;
        while (!t_valid[s] && k < 100) begin
            if (t_rden[s]) begin
                if (int'(t_addr[s]) != n_rd) addr_bad = 1'b1;
                n_rd++;
            end
            @(posedge clk); #1;
            k++;
        end
        chk("latency", k + 1, c_lat[s]);
        chk("rd_count", n_rd, c_nin[s]);
        chk("addr_seq", 32'(addr_bad), 0);
        for (int i = 0; i < 3; i++) chk("out_data", t_data[s][i], v.e[i]);
        chk("argmax", 32'(t_arg[s]), 32'(v.arg));
        if (stall) begin
            for (int c = 0; c < 5; c++) begin
                if (c == 2) t_start[s] = 1'b1;
                @(posedge clk); #1;
                t_start[s] = 1'b0;
                chk("stall_valid", 32'(t_valid[s]), 1);
                chk("stall_data", t_data[s][1], v.e[1]);
                chk("stall_argmax", 32'(t_arg[s]), 32'(v.arg));
            end
            t_ready[s] = 1'b1;
            t_start[s] = 1'b1;
        end
        @(posedge clk); #1;
        t_start[s] = 1'b0;
        chk("valid_drop", 32'(t_valid[s]), 0);
        chk("idle_busy", 32'(t_busy[s]), 0);
        chk("hold_data", t_data[s][2], v.e[2]);
        chk("hold_argmax", 32'(t_arg[s]), 32'(v.arg));
        if (stall) begin
            @(posedge clk); #1;
            chk("start_ignored", 32'(t_busy[s]), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        cur = '0;
        bias_drv = '0;
        for (int s = 0; s < 4; s++) begin
            t_start[s] = 1'b0;
            t_ready[s] = 1'b0;
        end
        vecs[0] = mkv(0, {32'd1, 32'd2, 32'd3, 32'd4}, {4{32'd1}}, {4{-32'sd1}}, {4{32'd2}},
                      {32'd0, 32'd0, 32'd5}, {32'd10, 32'd0, 32'd25}, 2);
        vecs[1] = mkv(1, {32'd1, 32'd2, 32'd3, 32'd4}, {4{32'd1}}, {4{-32'sd1}}, {4{32'd2}},
                      {32'd0, 32'd0, 32'd5}, {32'd10, -32'sd10, 32'd25}, 2);
        vecs[2] = mkv(0, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd2, 32'd3, 32'd4},
                      {32'd4, 32'd3, 32'd2, 32'd1}, {32'd0, 32'd0, 32'd0, -32'sd1},
                      {32'd0, 32'd5, 32'd0}, {32'd30, 32'd25, 32'd0}, 0);
        vecs[3] = mkv(0, {4{32'd1}}, {4{32'd1}}, {32'd2, 32'd1, 32'd1, 32'd0}, {4{32'd0}},
                      {32'd3, 32'd3, 32'd3}, {32'd7, 32'd7, 32'd3}, 0);
        vecs[4] = mkv(0, {4{32'd1}}, {4{32'd0}}, {4{32'd2}}, {4{32'd1}},
                      {32'd3, 32'd1, 32'd5}, {32'd3, 32'd9, 32'd9}, 1);
        vecs[5] = mkv(2, {4{32'd256}}, {4{32'd256}}, {4{32'd0}}, {4{32'd0}},
                      {32'd1, 32'd0, 32'd0}, {32'd1025, 32'd0, 32'd0}, 0);
        vecs[6] = mkv(2, {4{32'd256}}, {4{32'd32767}}, {4{-32'sd32767}}, {4{32'd1}},
                      {32'd0, 32'd0, 32'd0}, {32'd32767, -32'sd32768, 32'd4}, 0);
        vecs[7] = mkv(2, {4{32'd1}}, {4{-32'sd1}}, {4{32'd1}}, {4{32'd0}},
                      {32'd0, 32'd0, -32'sd3}, {-32'sd1, 32'd0, -32'sd3}, 1);
        vecs[8] = mkv(3, {32'd3, 32'd99, 32'd99, 32'd99}, {32'd5, 32'd99, 32'd99, 32'd99},
                      {-32'sd2, 32'd99, 32'd99, 32'd99}, {32'd2, 32'd99, 32'd99, 32'd99},
                      {32'd1, 32'd0, 32'd4}, {32'd16, 32'd0, 32'd10}, 0);

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            chk("rst_busy", 32'(t_busy[s]), 0);
            chk("rst_rd_en", 32'(t_rden[s]), 0);
            chk("rst_rd_addr", 32'(t_addr[s]), 0);
            chk("rst_valid", 32'(t_valid[s]), 0);
            chk("rst_argmax", 32'(t_arg[s]), 0);
            chk("rst_data", t_data[s][0], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i == 3);

        // Abort mid-FETCH, then a clean run must still be correct
        cur = vecs[0];
        bias_drv = vecs[0].b;
        t_start[0] = 1'b1;
        @(posedge clk); #1;
        t_start[0] = 1'b0;
        for (int k = 0; k < 20 && t_addr[0] != 2'd2; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_at_addr2", 32'(t_addr[0]), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(t_busy[0]), 0);
        chk("abort_rd_en", 32'(t_rden[0]), 0);
        chk("abort_rd_addr", 32'(t_addr[0]), 0);
        chk("abort_valid", 32'(t_valid[0]), 0);
        chk("abort_data", t_data[0][1], 0);
        chk("abort_argmax", 32'(t_arg[0]), 0);
        run_vec(vecs[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
